instr_fetch_buffer: RTL

Sits between the instruction fetch unit and the decode stage. Each cycle it presents the fetch PC to instruction memory, which has 1-cycle read latency, and captures the returned word tagged with its PC. It queues captured words in a small FIFO toward decode with a valid/ready handshake, and discards wrong-path words when a branch or jump is taken.

---
 rtl/riscv_pkg.sv | 10 +
 rtl/instr_fifo.sv | 41 ++++
 rtl/instr_fetch_buffer.sv | 64 ++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-path constants and the fetch-entry layout
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            misaligned;
  } fetch_entry_t;
endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: synchronous FIFO with clear and dropped-push indication
module instr_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     dropped
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   count_q;
  logic          full, do_push, do_pop;
  assign full    = count_q == (AW+1)'(DEPTH);
  assign do_pop  = pop & (count_q != '0) & ~clear;
  // a pop in the same cycle frees the slot a full-FIFO push needs
  assign do_push = push & (~full | do_pop) & ~clear;
  assign dropped = push & full & ~do_pop & ~clear;
  assign dout    = mem_q[rd_q];
  assign count   = count_q;
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_q + AW'(do_push);
      rd_q    <= rd_q + AW'(do_pop);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: captures 1-cycle-latency imem words with their PC and queues them to decode
module instr_fetch_buffer #(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic            fetch_valid,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            flush,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic            id_misaligned,
  output logic            fetch_stall,
  output logic            overrun
);
  import riscv_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = 2*XLEN + 1;
  logic            req_valid_q, req_valid_d, overrun_q, overrun_d;
  logic [XLEN-1:0] req_pc_q;
  logic [CW-1:0]   count;
  logic [EW-1:0]   head, din;
  logic            mis, push, pop, dropped;
  assign imem_addr = fetch_pc;
  assign mis  = |req_pc_q[1:0];
  // entry layout {pc, instr, misaligned}; misaligned fetches become NOPs
  assign din  = {req_pc_q, mis ? XLEN'(NOP_INSTR) : imem_rdata, mis};
  assign push = req_valid_q & ~flush;
  assign id_valid      = (count != '0) & ~flush;
  assign pop           = id_valid & id_ready;
  assign id_pc         = id_valid ? head[EW-1 -: XLEN] : '0;
  assign id_instr      = id_valid ? head[XLEN:1] : XLEN'(NOP_INSTR);
  assign id_misaligned = id_valid & head[0];
  assign fetch_stall   = ({1'b0, count} + (CW+1)'(req_valid_q)) >= (CW+1)'(DEPTH);
  assign overrun       = overrun_q;
  assign req_valid_d   = fetch_valid & ~flush;
  assign overrun_d     = overrun_q | dropped;
  always_ff @(posedge clk) begin
    req_pc_q <= fetch_pc;
    if (reset) begin
      req_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      req_valid_q <= req_valid_d;
      overrun_q   <= overrun_d;
    end
  end
  instr_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear   (flush),
    .push    (push),
    .pop     (pop),
    .din     (din),
    .dout    (head),
    .count   (count),
    .dropped (dropped)
  );
endmodule
